// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin arbitration between two writeback
// requesters plus a sequencer that zeroes registers 1..2^ADDR_W-1.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              RegWEn
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CNT_LAST  = {ADDR_W{1'b1}};

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   cnt_d;
  logic                last_q;   // 1: requester 1 was granted most recently
  logic [ADDR_W-1:0]   a3_q;
  logic [DATA_W-1:0]   wd3_q;
  logic                we_q;
  logic                busy_q;
  logic                grant1;
  logic                accept_ok;

  // Grant selection and combinational ready handshake
  always_comb begin
    grant1    = 1'b0;
    accept_ok = 1'b0;
    cnt_d     = cnt_q + CNT_FIRST;
    if (req0_valid && req1_valid) begin
      grant1 = ~last_q;
    end else begin
      grant1 = req1_valid;
    end
    accept_ok  = ~Reset && (state_q == IDLE) && ~clear_start;
    req0_ready = accept_ok && req0_valid && ~grant1;
    req1_ready = accept_ok && req1_valid && grant1;
  end

  // Arbitration/clear FSM with registered write-port outputs
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_FIRST;
      last_q  <= 1'b1;
      a3_q    <= '0;
      wd3_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            // First clear write is presented in the very first CLEAR cycle
            state_q <= CLEAR;
            cnt_q   <= CNT_FIRST;
            a3_q    <= CNT_FIRST;
            wd3_q   <= '0;
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (req0_ready) begin
            a3_q   <= req0_addr;
            wd3_q  <= req0_data;
            we_q   <= (req0_addr != '0);
            last_q <= 1'b0;
          end else if (req1_ready) begin
            a3_q   <= req1_addr;
            wd3_q  <= req1_data;
            we_q   <= (req1_addr != '0);
            last_q <= 1'b1;
          end else begin
            we_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            a3_q  <= cnt_d;
            wd3_q <= '0;
            we_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A3         = a3_q;
  assign WD3        = wd3_q;
  assign RegWEn     = we_q;
  assign clear_busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: single write, contention, x0 drop,
// clear sequence and reset during clear.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        Reset;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        clear_start;
  logic        clear_busy;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        RegWEn;

  int n_cmp;
  int n_err;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .A3         (A3),
    .WD3        (WD3),
    .RegWEn     (RegWEn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    Reset       = 1'b1;
    req0_valid  = 1'b1;
    req0_addr   = 5'd5;
    req0_data   = 32'h0;
    req1_valid  = 1'b1;
    req1_addr   = 5'd6;
    req1_data   = 32'h0;
    clear_start = 1'b0;
    step();
    step();
    check_eq("rst_a3",     64'(A3), 64'd0);
    check_eq("rst_wd3",    64'(WD3), 64'd0);
    check_eq("rst_we",     64'(RegWEn), 64'd0);
    check_eq("rst_busy",   64'(clear_busy), 64'd0);
    check_eq("rst_ready0", 64'(req0_ready), 64'd0);
    check_eq("rst_ready1", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    Reset      = 1'b0;
    step();

    // Single request
    req0_valid = 1'b1;
    req0_addr  = 5'd5;
    req0_data  = 32'hDEADBEEF;
    #1;
    check_eq("single_ready0", 64'(req0_ready), 64'd1);
    check_eq("single_ready1", 64'(req1_ready), 64'd0);
    step();
    req0_valid = 1'b0;
    check_eq("single_a3",  64'(A3), 64'd5);
    check_eq("single_wd3", 64'(WD3), 64'hDEADBEEF);
    check_eq("single_we",  64'(RegWEn), 64'd1);
    step();
    check_eq("single_we_off", 64'(RegWEn), 64'd0);
    check_eq("single_a3_hold", 64'(A3), 64'd5);
    check_eq("single_wd3_hold", 64'(WD3), 64'hDEADBEEF);

    // Contention right after reset: requester 0 wins first, then alternate
    do_reset();
    req0_valid = 1'b1;
    req0_addr  = 5'd3;
    req0_data  = 32'h000000A0;
    req1_valid = 1'b1;
    req1_addr  = 5'd4;
    req1_data  = 32'h000000B1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("cont_ready0_%0d", i), 64'(req0_ready), 64'((i % 2) == 0));
      check_eq($sformatf("cont_ready1_%0d", i), 64'(req1_ready), 64'((i % 2) == 1));
      step();
      check_eq($sformatf("cont_a3_%0d", i), 64'(A3), (i % 2 == 0) ? 64'd3 : 64'd4);
      check_eq($sformatf("cont_wd3_%0d", i), 64'(WD3), (i % 2 == 0) ? 64'hA0 : 64'hB1);
      check_eq($sformatf("cont_we_%0d", i), 64'(RegWEn), 64'd1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check_eq("cont_idle_we", 64'(RegWEn), 64'd0);

    // Write to x0: handshake completes, no write enable
    req1_valid = 1'b1;
    req1_addr  = 5'd0;
    req1_data  = 32'h00001234;
    #1;
    check_eq("x0_ready1", 64'(req1_ready), 64'd1);
    step();
    req1_valid = 1'b0;
    check_eq("x0_we", 64'(RegWEn), 64'd0);
    step();
    check_eq("x0_we_after", 64'(RegWEn), 64'd0);

    // Clear with a pending req0 (and a stray clear_start mid-sequence)
    req0_valid  = 1'b1;
    req0_addr   = 5'd7;
    req0_data   = 32'h00000077;
    clear_start = 1'b1;
    #1;
    check_eq("clr_start_ready0", 64'(req0_ready), 64'd0);
    step();
    clear_start = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      clear_start = (k == 5);
      #1;
      check_eq($sformatf("clr_a3_%0d", k), 64'(A3), 64'(k));
      check_eq($sformatf("clr_wd3_%0d", k), 64'(WD3), 64'd0);
      check_eq($sformatf("clr_we_%0d", k), 64'(RegWEn), 64'd1);
      check_eq($sformatf("clr_busy_%0d", k), 64'(clear_busy), 64'd1);
      check_eq($sformatf("clr_ready0_%0d", k), 64'(req0_ready), 64'd0);
      step();
    end
    clear_start = 1'b0;
    #1;
    check_eq("clr_done_busy", 64'(clear_busy), 64'd0);
    check_eq("clr_done_we", 64'(RegWEn), 64'd0);
    check_eq("clr_done_ready0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    check_eq("clr_post_a3", 64'(A3), 64'd7);
    check_eq("clr_post_wd3", 64'(WD3), 64'h77);
    check_eq("clr_post_we", 64'(RegWEn), 64'd1);

    // Reset during clear at step A3=10
    step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    check_eq("mid_a3_pre", 64'(A3), 64'd10);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("mid_a3", 64'(A3), 64'd0);
    check_eq("mid_wd3", 64'(WD3), 64'd0);
    check_eq("mid_we", 64'(RegWEn), 64'd0);
    check_eq("mid_busy", 64'(clear_busy), 64'd0);
    step();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("mid_after_we_%0d", k), 64'(RegWEn), 64'd0);
      check_eq($sformatf("mid_after_a3_%0d", k), 64'(A3), 64'd0);
      check_eq($sformatf("mid_after_busy_%0d", k), 64'(clear_busy), 64'd0);
    end
    req0_valid = 1'b1;
    req0_addr  = 5'd9;
    req0_data  = 32'h00000099;
    #1;
    check_eq("mid_idle_ready0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    check_eq("mid_idle_a3", 64'(A3), 64'd9);
    check_eq("mid_idle_we", 64'(RegWEn), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of writeback data and WD3.
REQ-002 Parameter: ADDR_W, 5, register address width; the file holds 2^ADDR_W registers.
REQ-003 clock  input  1  single clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  reset, asynchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-006 req0_addr  input  ADDR_W  requester 0 destination register.
REQ-007 req0_data  input  DATA_W  requester 0 write value.
REQ-008 req0_ready  output  1  requester 0 write is accepted this cycle.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready: the same as REQ-005..008 for requester 1 (load/multi-cycle unit).
REQ-010 clear_start  input  1  single-cycle pulse that requests zeroing of registers 1..2^ADDR_W-1.
REQ-011 clear_busy  output  1  clear sequence in progress.
REQ-012 A3  output  ADDR_W  register-file write address, registered.
REQ-013 WD3  output  DATA_W  register-file write data, registered.
REQ-014 RegWEn  output  1  register-file write enable, registered.

Function
REQ-015 The block SHALL own the single register-file write port and share it between two requesters plus an internal clear sequencer.
REQ-016 FSM states SHALL be IDLE and CLEAR.
REQ-017 Handshake: a write transfers in the cycle where reqN_valid and reqN_ready are both 1; reqN_data and reqN_addr SHALL be sampled on that edge.
REQ-018 reqN_ready SHALL be combinational; it is 1 only if the state is IDLE, clear_start is 0, reqN_valid is 1, and requester N holds the grant.
REQ-019 At most one reqN_ready SHALL be 1 in any cycle.
REQ-020 Grant: when only one requester is valid, that requester SHALL receive the grant.
REQ-021 Round-robin: when both requesters are valid, the requester not granted most recently SHALL receive the grant; the last-grant pointer SHALL update only on a completed transfer.
REQ-022 Latency: a transfer at edge E SHALL drive A3=addr, WD3=data, RegWEn=1 during the cycle following E (1 cycle).
REQ-023 RegWEn SHALL be 0 in any IDLE cycle that follows an edge with no transfer; A3 and WD3 SHALL then hold their previous values.
REQ-024 A transfer with addr==0 SHALL complete the handshake normally, but RegWEn SHALL stay 0 for it.
REQ-025 In IDLE, clear_start=1 SHALL move the FSM to CLEAR at the next edge and load the counter with 1; no request is accepted in that cycle.
REQ-026 In CLEAR, each cycle SHALL drive A3=counter, WD3=0, RegWEn=1, and the counter SHALL increment.
REQ-027 After the counter reaches 2^ADDR_W-1, the FSM SHALL return to IDLE. The counter does not wrap to 0, and register 0 is never written.
REQ-028 The clear SHALL take exactly 2^ADDR_W-1 (31) write cycles. clear_busy SHALL be 1 from the edge that enters CLEAR through the last clear write cycle.
REQ-029 In CLEAR, both reqN_ready SHALL be 0, and clear_start SHALL be ignored.
REQ-030 A requester that stays valid during CLEAR SHALL keep its request pending, and it is served in the first IDLE cycle.

Reset
REQ-031 Reset=1 SHALL force the following asynchronously: state IDLE, RegWEn=0, A3=0, WD3=0, clear_busy=0, counter=1, last-grant pointer = requester 1 (so requester 0 wins the first contention).
REQ-032 Reset asserted mid-CLEAR SHALL abort the sequence with no further writes. After Reset is released, no clear resumes without a new clear_start.
REQ-033 While Reset=1, both reqN_ready SHALL be 0.

Verification
REQ-034 Single request: req0 addr=5, data=0xDEADBEEF, valid for 1 cycle -> ready=1 that cycle; the next cycle shows A3=5, WD3=0xDEADBEEF, RegWEn=1; the cycle after shows RegWEn=0.
REQ-035 Contention: both valid continuously after reset, addrs 3 and 4 -> grants alternate 0,1,0,1; RegWEn=1 for 4 consecutive cycles with A3 sequence 3,4,3,4.
REQ-036 x0 drop: req1 addr=0, data=0x1234 -> handshake completes; RegWEn remains 0.
REQ-037 Clear: pulse clear_start in IDLE while req0 is valid -> req0_ready=0. Then 31 cycles show A3=1..31, WD3=0, RegWEn=1, clear_busy=1. Then req0 is accepted in the first IDLE cycle.
REQ-038 Reset mid-clear: assert Reset at clear step A3=10 -> all outputs are 0 immediately; after release, the FSM is in IDLE and no write to A3=11 occurs.
